ma_axis_pipe: RTL
=================

Name: ma_axis_pipe

Overview:
- Three-input signed multiply-add stream engine: accepts operand beats A, B, C on independent valid/ready slave channels and produces one result per joined beat on a valid/ready master channel.
- Successor to the fixed 16-bit, 3-stage multiply-add block:
  - parametrised data width, accumulator width and pipeline depth;
  - per-beat mode select (add, subtract, accumulate);
  - true backpressure with bubble collapse, so no data is lost or zeroed when m_ready drops.
- Sits between operand producers and a downstream stream consumer in the DSP datapath.

Parameters:
- DATA_W, 16, width of each signed operand A/B/C.
- ACC_W, 40, width of signed result/accumulator; legal range 2*DATA_W+1 to 64.
- PIPE_STAGES, 3, register stages from input acceptance to output register; legal range 2 to 8.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- A  in  DATA_W  signed operand A.
- a_valid  in  1  A beat valid.
- a_ready  out  1  A beat accepted.
- B  in  DATA_W  signed operand B.
- b_valid  in  1  B beat valid.
- b_ready  out  1  B beat accepted.
- C  in  DATA_W  signed operand C.
- c_valid  in  1  C beat valid.
- c_ready  out  1  C beat accepted.
- mode  in  2  op for the joined beat, sampled with it: 00 MADD, 01 MSUB, 10 MAC, 11 reserved (treated as MADD).
- first  in  1  MAC only: beat starts a new accumulation.
- m_data  out  ACC_W  signed result.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- busy  out  1  any pipeline stage holds a valid beat.

Behaviour:
- Reset (asynchronous assert; release synchronous to clk) clears:
  - all stage valids and m_valid (0);
  - m_data (0), accumulator (0), busy (0);
  - a_ready/b_ready/c_ready (0).
- Reset mid-operation discards all in-flight beats; no result for them ever appears.
- Join rule:
  - fire_in = a_valid & b_valid & c_valid & adv[0].
  - a_ready = b_ready = c_ready = fire_in; all three handshakes complete in the same cycle.
  - A valid on one channel alone is held, never consumed.
  - mode and first are sampled only on fire_in.
- Stage advance:
  - Stage k = PIPE_STAGES-1 is the output register.
  - adv[k] = !v[k] | m_ready.
  - adv[i] = !v[i] | adv[i+1].
  - Bubbles collapse; a stalled stage holds its data and valid unchanged.
- Throughput: one beat per cycle when m_ready stays high.
- Latency: fire_in at cycle t gives m_valid=1 at cycle t+PIPE_STAGES with no stall.
- Ordering: strictly in order.
- AXI stability: once m_valid=1 and m_ready=0, m_valid and m_data hold until the handshake completes.
- Arithmetic:
  - Product A*B is full-precision signed (2*DATA_W bits), computed in stage 0/1.
  - All operands are sign-extended to ACC_W before add/sub.
  - MADD: result = A*B + C.
  - MSUB: result = A*B - C.
  - MAC, first=1: acc = C + A*B; result = acc.
  - MAC, first=0: acc = acc + A*B; C is ignored; result = acc.
  - Overflow wraps in two's complement at ACC_W bits; no saturation.
- Accumulator timing:
  - Updates only when a MAC beat enters the output stage (adv[k] & v[k-1] & mode_k-1==MAC).
  - MADD/MSUB beats leave acc untouched, so MAC runs may be interleaved with MADD/MSUB beats.
  - MAC with first=0 directly after reset accumulates onto 0.
- busy = OR of all stage valids.
- Simultaneous input accept and output drain in the same cycle with a full pipe is legal: no bubble is inserted.

Decomposition:
- Package ma_axis_pkg:
  - mode encodings MODE_MADD=2'b00, MODE_MSUB=2'b01, MODE_MAC=2'b10;
  - localparam PROD_W = 2*DATA_W;
  - min/max legality constants for ACC_W and PIPE_STAGES, checked by elaboration assertion.
- One sub-module, ma_axis_stage:
  - a single valid/enable register slice, parametrised payload width, with the advance logic;
  - instantiated in a generate loop for the PIPE_STAGES-2 delay stages between the multiply stage and the output stage.

Test Plan:
- MADD, DATA_W=16, PIPE_STAGES=3, m_ready=1: A=3, B=-4, C=5, all valid at t -> m_data=-7, m_valid=1 at t+3, and the readies pulse only at t.
- Skewed valids: a_valid at t, b_valid at t+2, c_valid at t+4 -> all three readies pulse together at t+4, and the result appears at t+7.
- Backpressure: stream 6 beats back to back, m_ready=0 for cycles 4-8 -> no loss or duplication, m_data held stable while stalled, readies drop once the pipe is full, all 6 results in order.
- MAC: beats (first=1, C=10, A=2, B=3), (first=0, A=4, B=5), (first=0, A=-1, B=6) -> outputs 16, 36, 30; an interleaved MADD beat (A=1, B=1, C=1) gives 2 without disturbing acc.
- Wrap: ACC_W=33, MAC of A=-32768, B=-32768 repeated 3 times with first=1 on the first beat (C=0) -> each result equals the exact sum modulo 2^33, sign-interpreted.
- Async reset asserted mid-stream with 3 beats in flight and m_valid=1 -> m_valid, busy and m_data are 0 immediately, without waiting for a clock edge; after release, the first new beat returns a correct result with acc starting at 0.

Source files
------------

// File: rtl/ma_axis_pkg.sv
// Shared constants for the multiply-add stream engine: mode encodings,
// product width helper and parameter legality limits.
package ma_axis_pkg;

    localparam logic [1:0] MODE_MADD = 2'b00;
    localparam logic [1:0] MODE_MSUB = 2'b01;
    localparam logic [1:0] MODE_MAC  = 2'b10;

    localparam int DEF_DATA_W = 16;
    localparam int PROD_W     = 2 * DEF_DATA_W;

    localparam int ACC_W_MAX  = 64;
    localparam int PIPE_MIN   = 2;
    localparam int PIPE_MAX   = 8;

    function automatic int prod_w(input int data_w);
        return 2 * data_w;
    endfunction

    // Narrowest accumulator that holds a full product plus sign headroom.
    function automatic int acc_w_min(input int data_w);
        return 2 * data_w + 1;
    endfunction

endpackage

// File: rtl/ma_axis_stage.sv
// One valid/payload register slice with skid-free advance: loads whenever it
// is empty or the downstream slice is moving, otherwise holds.
module ma_axis_stage #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_vld,
    input  logic [W-1:0] i_data,
    input  logic         i_adv_next,
    output logic         o_adv,
    output logic         o_vld,
    output logic [W-1:0] o_data
);

    logic         r_vld;
    logic [W-1:0] r_data;

    assign o_adv  = !r_vld || i_adv_next;
    assign o_vld  = r_vld;
    assign o_data = r_data;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_vld  <= 1'b0;
            r_data <= '0;
        end else if (o_adv) begin
            r_vld <= i_vld;
            if (i_vld) r_data <= i_data;
        end
    end

endmodule

// File: rtl/ma_axis_pipe.sv
// Three-input signed multiply-add stream engine (MADD/MSUB/MAC) with joined
// valid/ready inputs, collapsing pipeline and a held output register.
module ma_axis_pipe
    import ma_axis_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ACC_W       = 40,
    parameter int PIPE_STAGES = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] A,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic signed [DATA_W-1:0] B,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic signed [DATA_W-1:0] C,
    input  logic                     c_valid,
    output logic                     c_ready,
    input  logic [1:0]               mode,
    input  logic                     first,
    output logic signed [ACC_W-1:0]  m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     busy
);

    localparam int PW   = prod_w(DATA_W);
    localparam int PL_W = PW + DATA_W + 3;
    localparam int K    = PIPE_STAGES;

    if (ACC_W < acc_w_min(DATA_W) || ACC_W > ACC_W_MAX ||
        PIPE_STAGES < PIPE_MIN || PIPE_STAGES > PIPE_MAX) begin : g_param_err
        $error("ma_axis_pipe: illegal ACC_W or PIPE_STAGES");
    end

    logic [K-1:0]    w_adv;
    logic [K-1:0]    w_vld;
    logic [PL_W-1:0] w_pl [K-1];
    logic            w_fire;
    logic [1:0]      w_mode_in;

    // Input stage: operand capture on the joined handshake.
    logic                     r_v0;
    logic signed [DATA_W-1:0] r_a, r_b, r_c;
    logic [1:0]               r_mode;
    logic                     r_first;
    logic signed [PW-1:0]     w_prod;

    assign w_adv[0]  = !r_v0 || w_adv[1];
    assign w_fire    = a_valid && b_valid && c_valid && w_adv[0];
    assign a_ready   = w_fire && !reset;
    assign b_ready   = w_fire && !reset;
    assign c_ready   = w_fire && !reset;
    assign w_mode_in = (mode == MODE_MSUB || mode == MODE_MAC) ? mode : MODE_MADD;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v0    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_mode  <= MODE_MADD;
            r_first <= 1'b0;
        end else if (w_adv[0]) begin
            r_v0 <= w_fire;
            if (w_fire) begin
                r_a     <= A;
                r_b     <= B;
                r_c     <= C;
                r_mode  <= w_mode_in;
                r_first <= first;
            end
        end
    end

    assign w_prod   = PW'(r_a) * PW'(r_b);
    assign w_vld[0] = r_v0;
    assign w_pl[0]  = {w_prod, r_c, r_mode, r_first};

    for (genvar i = 1; i < K - 1; i++) begin : g_dly
        ma_axis_stage #(.W(PL_W)) u_stage (
            .i_clk      (clk),
            .i_reset    (reset),
            .i_vld      (w_vld[i-1]),
            .i_data     (w_pl[i-1]),
            .i_adv_next (w_adv[i+1]),
            .o_adv      (w_adv[i]),
            .o_vld      (w_vld[i]),
            .o_data     (w_pl[i])
        );
    end

    // Output stage: final add/sub/accumulate lands directly in the held register.
    logic                     r_mv;
    logic signed [ACC_W-1:0]  r_md;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [PW-1:0]     w_o_prod;
    logic signed [DATA_W-1:0] w_o_c;
    logic [1:0]               w_o_mode;
    logic                     w_o_first;
    logic signed [ACC_W-1:0]  w_px, w_cx, w_acc_nxt, w_res;
    logic                     w_take;

    assign w_o_prod  = w_pl[K-2][PL_W-1 -: PW];
    assign w_o_c     = w_pl[K-2][3 +: DATA_W];
    assign w_o_mode  = w_pl[K-2][2:1];
    assign w_o_first = w_pl[K-2][0];
    assign w_px      = {{(ACC_W-PW){w_o_prod[PW-1]}}, w_o_prod};
    assign w_cx      = {{(ACC_W-DATA_W){w_o_c[DATA_W-1]}}, w_o_c};
    assign w_acc_nxt = w_o_first ? (w_cx + w_px) : (r_acc + w_px);

    always_comb begin
        w_res = w_px + w_cx;
        case (w_o_mode)
            MODE_MSUB: w_res = w_px - w_cx;
            MODE_MAC:  w_res = w_acc_nxt;
            default:   w_res = w_px + w_cx;
        endcase
    end

    assign w_adv[K-1] = !r_mv || m_ready;
    assign w_vld[K-1] = r_mv;
    assign w_take     = w_adv[K-1] && w_vld[K-2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mv  <= 1'b0;
            r_md  <= '0;
            r_acc <= '0;
        end else begin
            if (w_adv[K-1]) r_mv <= w_vld[K-2];
            if (w_take) begin
                r_md <= w_res;
                if (w_o_mode == MODE_MAC) r_acc <= w_acc_nxt;
            end
        end
    end

    assign m_data  = r_md;
    assign m_valid = r_mv;
    assign busy    = |w_vld;

endmodule
